// File: rtl/six_by_three_divider_if.sv
// Handshake and data bundle for the 6-bit by 3-bit restoring divider.
// The master drives the operands and start; the slave returns results and status.
interface six_by_three_divider_if;
  logic       start;
  logic [5:0] dividend;
  logic [2:0] divisor;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/six_by_three_divider.sv
// Sequential restoring divider: 6-bit dividend by 3-bit divisor, one quotient bit per cycle.
// A zero divisor skips the iterations and reports all-ones quotient with an error flag.
module six_by_three_divider (
  input logic                    clk,
  input logic                    rst_n,
  six_by_three_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [5:0] shift_q;
  logic [2:0] dvs;
  logic [3:0] part_rem;
  logic [2:0] count;

  logic [4:0] shifted;
  logic       q_bit;
  logic [3:0] diff;

  // The dividend register doubles as the quotient accumulator: bits leave at the top, quotient bits enter at the bottom.
  always_comb begin
    shifted = {part_rem, shift_q[5]};
    q_bit   = (shifted >= {2'b00, dvs});
    diff    = q_bit ? (shifted[3:0] - {1'b0, dvs}) : shifted[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shift_q         <= 6'd0;
      dvs             <= 3'd0;
      part_rem        <= 4'd0;
      count           <= 3'd0;
      bus.quotient    <= 6'd0;
      bus.remainder   <= 3'd0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_q <= bus.dividend;
            dvs     <= bus.divisor;
            if (bus.divisor == 3'd0) begin
              state           <= DONE;
              bus.quotient    <= 6'h3F;
              bus.remainder   <= 3'd0;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
            end else begin
              state           <= RUN;
              bus.busy        <= 1'b1;
              bus.div_by_zero <= 1'b0;
              part_rem        <= 4'd0;
              count           <= 3'd6;
            end
          end
        end
        RUN: begin
          shift_q  <= {shift_q[4:0], q_bit};
          part_rem <= diff;
          count    <= count - 3'd1;
          if (count == 3'd1) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.quotient  <= {shift_q[4:0], q_bit};
            bus.remainder <= diff[2:0];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_six_by_three_divider.sv
// Scoreboard bench for six_by_three_divider: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done pulses.
module tb_six_by_three_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  six_by_three_divider_if bus ();

  six_by_three_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int q;
    int r;
    int dbz;
    int done_cyc;
    int busy_cycles;
  } exp_t;

  exp_t sb[$];
  int check_count = 0;
  int pass_count  = 0;
  int done_total  = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  int   busy_run  = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        done_total++;
        checkOutput("done_width", int'(prev_done), 0);
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("quotient",    int'(bus.quotient),    e.q);
          checkOutput("remainder",   int'(bus.remainder),   e.r);
          checkOutput("div_by_zero", int'(bus.div_by_zero), e.dbz);
          checkOutput("latency",     cyc,                   e.done_cyc);
          checkOutput("busy_cycles", busy_run,              e.busy_cycles);
        end
        busy_run = 0;
      end
      prev_done = bus.done;
    end
  end

  function automatic exp_t makeExp(input int q, input int r, input int dbz, input int accept_cyc, input int dvs);
    exp_t e;
    e.q           = q;
    e.r           = r;
    e.dbz         = dbz;
    e.done_cyc    = accept_cyc + ((dvs == 0) ? 0 : 6);
    e.busy_cycles = (dvs == 0) ? 0 : 6;
    return e;
  endfunction

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input int dvd, input int dvs, input int q, input int r, input int dbz);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 6'(dvd);
    bus.divisor  = 3'(dvs);
    sb.push_back(makeExp(q, r, dbz, cyc + 1, dvs));
    @(posedge clk);
    #1 bus.start = 1'b0;
    waitDrain();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_quotient"},    int'(bus.quotient),    0);
    checkOutput({tag, "_remainder"},   int'(bus.remainder),   0);
    checkOutput({tag, "_busy"},        int'(bus.busy),        0);
    checkOutput({tag, "_done"},        int'(bus.done),        0);
    checkOutput({tag, "_div_by_zero"}, int'(bus.div_by_zero), 0);
  endtask

  initial begin
    int dones_before;
    bus.start    = 1'b0;
    bus.dividend = 6'd0;
    bus.divisor  = 3'd0;

    #2 rst_n = 1'b0;
    #1 checkAllZero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(49, 7, 7, 0, 0);
    applyStimulus(63, 5, 12, 3, 0);
    applyStimulus(5, 7, 0, 5, 0);
    applyStimulus(42, 0, 63, 0, 1);
    applyStimulus(13, 3, 4, 1, 0);

    // Restart attempt in the middle of a run must be ignored.
    dones_before = done_total;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 6'd49; bus.divisor = 3'd7;
    sb.push_back(makeExp(7, 0, 0, cyc + 1, 7));
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 6'd10; bus.divisor = 3'd2;
    @(negedge clk);
    bus.start = 1'b0;
    waitDrain();
    repeat (12) @(negedge clk);
    checkOutput("single_done", done_total - dones_before, 1);

    // Start held high: one operation every 8 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 6'd13; bus.divisor = 3'd3;
    sb.push_back(makeExp(4, 1, 0, cyc + 1, 3));
    sb.push_back(makeExp(4, 1, 0, cyc + 9, 3));
    waitDrain();
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the third RUN cycle aborts with no done.
    dones_before = done_total;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 6'd63; bus.divisor = 3'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllZero("abort");
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("start_in_reset_busy", int'(bus.busy), 0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("abort_no_done", done_total - dones_before, 0);
    applyStimulus(20, 6, 3, 2, 0);

    for (int dv = 0; dv < 64; dv++) begin
      for (int ds = 0; ds < 8; ds++) begin
        if (ds == 0) applyStimulus(dv, ds, 63, 0, 1);
        else         applyStimulus(dv, ds, dv / ds, dv % ds, 0);
      end
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/six_by_three_divider.md
SIX_BY_THREE_DIVIDER -- requirements
Module: six_by_three_divider

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed to pair with the 3x3 multiplier (6-bit product, 3-bit operands).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 dividend  input  6  unsigned dividend; captured on accepted start.
REQ-006 divisor  input  3  unsigned divisor; captured on accepted start.
REQ-007 quotient  output  6  unsigned quotient; registered.
REQ-008 remainder  output  3  unsigned remainder; registered.
REQ-009 busy  output  1  high while a division is in progress (RUN state).
REQ-010 done  output  1  one-cycle pulse; results valid and stable from this cycle.
REQ-011 div_by_zero  output  1  error flag for the most recent operation; registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at a rising edge SHALL latch dividend and divisor and leave IDLE; start=0 SHALL keep IDLE.
REQ-014 Accepted start with divisor!=0 SHALL go to RUN, clear div_by_zero, load the 4-bit partial remainder with 0, load the iteration counter with 6.
REQ-015 Accepted start with divisor==0 SHALL go directly to DONE with quotient=6'h3F, remainder=3'd0, div_by_zero=1.
REQ-016 RUN SHALL perform one restoring-division step per cycle, MSB of dividend first: shift partial remainder left by one, bringing in the next dividend bit; if shifted value >= {1'b0,divisor}, subtract divisor and set that quotient bit to 1, else quotient bit 0.
REQ-017 The partial remainder SHALL be 4 bits internally; no step SHALL overflow it (divisor <= 7 keeps it < 14).
REQ-018 After the 6th step the FSM SHALL go to DONE; quotient and remainder outputs SHALL be updated on that same edge.
REQ-019 Latency: with start accepted at edge N, done SHALL be high in the cycle following edge N+6 (nonzero divisor) or following edge N+1... specifically following edge N (divisor zero); done SHALL be high for exactly one cycle.
REQ-020 DONE SHALL return to IDLE unconditionally on the next edge; start during DONE SHALL be ignored.
REQ-021 busy SHALL be 1 exactly while in RUN (6 cycles per nonzero-divisor operation); 0 in IDLE and DONE.
REQ-022 start during RUN SHALL be ignored; operand inputs changing during RUN SHALL NOT affect the result.
REQ-023 quotient, remainder, div_by_zero SHALL hold their last values from DONE until the next operation completes; they SHALL NOT show intermediate step values.
REQ-024 Results SHALL satisfy dividend == quotient*divisor + remainder, with remainder < divisor, for every dividend 0..63 and divisor 1..7.
REQ-025 Back-to-back: start held high continuously SHALL produce one operation per 8 cycles (accept, 6 RUN, DONE, then re-accept in IDLE).

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force state IDLE, counter 0, partial remainder 0, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after rst_n rises SHALL be accepted normally.
REQ-028 start SHALL NOT be accepted on any edge where rst_n is low.

Verification
REQ-029 dividend=49, divisor=7, start pulse -> busy 6 cycles, done one cycle later: quotient=7, remainder=0, div_by_zero=0.
REQ-030 dividend=63, divisor=5 -> quotient=12, remainder=3; dividend=5, divisor=7 -> quotient=0, remainder=5.
REQ-031 dividend=42, divisor=0 -> done in cycle after accept edge, busy never high, quotient=63, remainder=0, div_by_zero=1; next 13/3 -> 4 r 1, div_by_zero=0.
REQ-032 Start 49/7, re-pulse start with 10/2 during RUN -> single done with 7 r 0; no second done.
REQ-033 Start 63/5, assert rst_n low at 3rd RUN cycle -> all outputs 0 at once, no done; after release 20/6 -> 3 r 2.
REQ-034 Exhaustive sweep dividend 0..63 x divisor 0..7 against REQ-015/REQ-024 model, checking done-pulse width and latency each case.
